state_dump_streamer: RTL and testbench

- Sits downstream of the single-cycle machine and consumes its architectural state after a run.
- On a start pulse, it walks register-file entries 0..NUM_REGS-1 and then a window of data-memory words.
- Each value is emitted as one record on a valid/ready stream toward the dump/check logic.
- Replaces the bench-side loops that print the register file and memory state, so the final state is checkable in hardware.

---
 rtl/state_dump_streamer.sv | 110 +++++++++++
 tb/tb_state_dump_streamer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_streamer.sv
// Walks the register file and a data-memory window after a run and
// streams every value out as a {kind, index, data} record.
module state_dump_streamer #(
    parameter int          NUM_REGS  = 32,
    parameter logic [31:0] MEM_BASE  = 32'h10010000,
    parameter int          MEM_WORDS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_kind,
    output logic [31:0] out_index,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, REG_RD, REG_OUT, MEM_RD, MEM_OUT, FIN
    } state_t;

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);
    localparam logic [7:0] LAST_MEM = 8'(MEM_WORDS - 1);

    state_t     state, state_nx;
    logic [4:0] reg_cnt;
    logic [7:0] mem_cnt;
    logic       fire;

    assign fire      = out_valid && out_ready;
    assign rf_raddr  = reg_cnt;
    assign out_valid = (state == REG_OUT) || (state == MEM_OUT);
    assign busy      = (state == REG_RD) || (state == REG_OUT) ||
                       (state == MEM_RD) || (state == MEM_OUT);
    assign done      = (state == FIN);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = REG_RD;
            REG_RD:  state_nx = REG_OUT;
            REG_OUT: begin
                if (fire) begin
                    if (reg_cnt != LAST_REG) state_nx = REG_RD;
                    else if (MEM_WORDS == 0) state_nx = FIN;
                    else                     state_nx = MEM_RD;
                end
            end
            MEM_RD:  state_nx = MEM_OUT;
            MEM_OUT: begin
                if (fire)
                    state_nx = (mem_cnt == LAST_MEM) ? FIN : MEM_RD;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            reg_cnt   <= '0;
            mem_cnt   <= '0;
            mem_addr  <= '0;
            out_kind  <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) reg_cnt <= '0;
                end
                REG_RD: begin
                    out_data  <= rf_rdata;
                    out_index <= {27'd0, reg_cnt};
                    out_kind  <= 1'b0;
                end
                REG_OUT: begin
                    if (fire && reg_cnt != LAST_REG) begin
                        reg_cnt <= reg_cnt + 5'd1;
                    end else if (fire && MEM_WORDS != 0) begin
                        mem_cnt  <= '0;
                        mem_addr <= MEM_BASE;
                    end
                end
                MEM_RD: begin
                    out_data  <= mem_rdata;
                    out_index <= mem_addr;
                    out_kind  <= 1'b1;
                end
                MEM_OUT: begin
                    // Address advances with the count; 32-bit wrap is intended
                    if (fire && mem_cnt != LAST_MEM) begin
                        mem_cnt  <= mem_cnt + 8'd1;
                        mem_addr <= mem_addr + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_streamer.sv
// Directed bench for state_dump_streamer with a record scoreboard
// and a second small instance (4 regs, no memory window).
module tb_state_dump_streamer;

    typedef struct packed {
        logic        kind;
        logic [31:0] idx;
        logic [31:0] data;
    } rec_t;

    localparam logic [31:0] BASE = 32'h10010000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_kind;
    logic [31:0] out_index;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic        start2 = 1'b0;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata2;
    logic [31:0] mem_addr2;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic        out_kind2;
    logic [31:0] out_index2;
    logic [31:0] out_data2;
    logic        busy2;
    logic        done2;

    logic [31:0] rf [32];
    logic [31:0] mem [8];
    logic [31:0] moff;

    rec_t q[$];
    rec_t q2[$];
    rec_t exp_r, exp_r2;

    int checks = 0;
    int passed = 0;
    int fails = 0;
    int rec_cnt = 0;
    int done_cnt = 0;
    int rec_cnt2 = 0;
    int done_cnt2 = 0;
    bit addr2_moved = 1'b0;

    always #5 clk = ~clk;

    assign rf_rdata  = rf[rf_raddr];
    assign rf_rdata2 = rf[rf_raddr2];
    assign moff      = mem_addr - BASE;
    assign mem_rdata = (moff < 32'd32) ? mem[moff[4:2]] : 32'hDEADBEEF;

    state_dump_streamer dut (
        .clk(clk), .reset(reset), .start(start),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_index(out_index),
        .out_data(out_data), .busy(busy), .done(done)
    );

    state_dump_streamer #(.NUM_REGS(4), .MEM_WORDS(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2),
        .mem_addr(mem_addr2), .mem_rdata(32'hBAD0BAD0),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_kind(out_kind2), .out_index(out_index2),
        .out_data(out_data2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [64:0] got,
                       input logic [64:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshakes complete on the next rising edge after this sample
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            rec_cnt++;
            if (q.size() == 0) begin
                chk("sb_underflow", 65'd1, 65'd0);
            end else begin
                exp_r = q.pop_front();
                chk("record", {out_kind, out_index, out_data}, exp_r);
            end
        end
        if (reset && done) done_cnt++;
        if (reset && out_valid2 && out_ready2) begin
            rec_cnt2++;
            if (q2.size() == 0) begin
                chk("sb2_underflow", 65'd1, 65'd0);
            end else begin
                exp_r2 = q2.pop_front();
                chk("record2", {out_kind2, out_index2, out_data2}, exp_r2);
            end
        end
        if (reset && done2) done_cnt2++;
        if (mem_addr2 != 32'd0) addr2_moved = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_full();
        for (int i = 0; i < 32; i++)
            q.push_back({1'b0, 32'(i), rf[i]});
        for (int j = 0; j < 5; j++)
            q.push_back({1'b1, BASE + 32'(4 * j), mem[j]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, {64'd0, out_valid}, 65'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 400) begin
            step();
            n++;
        end
        chk(tag, {64'd0, done}, 65'd1);
        step();
    endtask

    initial begin
        int n;
        int r0;
        int d0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
        for (int j = 0; j < 8; j++) mem[j] = 32'hA0 + 32'(j);

        #2;
        chk("rst_valid", {64'd0, out_valid}, 65'd0);
        chk("rst_busy_done", {63'd0, busy, done}, 65'd0);
        chk("rst_fields", {out_kind, out_index, out_data}, 65'd0);
        chk("rst_addrs", {28'd0, rf_raddr, mem_addr}, 65'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Full dump, no backpressure
        out_ready = 1'b1;
        push_full();
        r0 = rec_cnt;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!done && n < 200) begin
            if (busy) n++;
            step();
        end
        if (done) n++;
        chk("dump_len", 65'(n), 65'd75);
        step();
        chk("busy_after", {63'd0, busy, done}, 65'd0);
        chk("dumpA_recs", 65'(rec_cnt - r0), 65'd37);
        chk("dumpA_done", 65'(done_cnt - d0), 65'd1);
        chk("dumpA_empty", 65'(q.size()), 65'd0);

        // Stepped dump: capture hold, ignored restart, backpressure
        out_ready = 1'b0;
        push_full();
        r0 = rec_cnt;
        d0 = done_cnt;
        pulse_start();
        for (int r = 0; r < 37; r++) begin
            wait_valid("valid_wait");
            if (r == 2) begin
                rf[2] = 32'h55;
                step();
                chk("rf2_captured", 65'(out_data), 65'd6);
            end
            if (r == 10) pulse_start();
            if (r == 5) begin
                for (int k = 0; k < 10; k++) begin
                    chk("bp_valid", {64'd0, out_valid}, 65'd1);
                    chk("bp_idx_data", {out_index, out_data},
                        {33'd0, 32'd5, 32'd15} );
                    step();
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        wait_done("dumpB_done_seen");
        chk("dumpB_recs", 65'(rec_cnt - r0), 65'd37);
        chk("dumpB_done", 65'(done_cnt - d0), 65'd1);
        chk("dumpB_empty", 65'(q.size()), 65'd0);

        // Async reset while a memory record is pending
        push_full();
        pulse_start();
        n = 0;
        while (n < 40) begin
            wait_valid("valid_wait_c");
            if (out_kind) break;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            n++;
        end
        d0 = done_cnt;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", {63'd0, out_valid, busy}, 65'd0);
        q.delete();
        step();
        step();
        reset = 1'b1;
        step();
        step();
        chk("no_done_abort", 65'(done_cnt - d0), 65'd0);

        // Fresh dump after reset starts again at reg 0
        out_ready = 1'b1;
        push_full();
        r0 = rec_cnt;
        pulse_start();
        wait_done("dumpD_done_seen");
        chk("dumpD_recs", 65'(rec_cnt - r0), 65'd37);
        chk("dumpD_empty", 65'(q.size()), 65'd0);

        // Register-only instance
        out_ready2 = 1'b1;
        for (int i = 0; i < 4; i++)
            q2.push_back({1'b0, 32'(i), rf[i]});
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("e_recs", 65'(rec_cnt2), 65'd4);
        chk("e_done", 65'(done_cnt2), 65'd1);
        chk("e_empty", 65'(q2.size()), 65'd0);
        chk("e_memaddr", {64'd0, addr2_moved}, 65'd0);
        chk("e_idle", {63'd0, busy2, out_valid2}, 65'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
